// File: rtl/snac_btn_pkg.sv
// Shared types and default constants for the SNAC button debouncer.
// Defaults target the 28.375160 MHz core clock with a 5 ms debounce window.
package snac_btn_pkg;

    typedef enum logic [1:0] {
        S_LO,
        S_CHK_HI,
        S_HI,
        S_CHK_LO
    } btn_state_t;

    localparam int CLK_HZ = 28375160;

    localparam int DEF_NUM_BUTTONS = 16;
    localparam int DEF_SYNC_STAGES = 2;
    // 5 ms of clk, rounded to the nearest cycle
    localparam int DEF_DEBOUNCE_CYCLES = (CLK_HZ + 100) / 200;
    localparam int DEF_TICK_DIV = 28;
    localparam int DEF_DEBOUNCE_TICKS = 5000;

endpackage

// File: rtl/snac_button_debouncer_if.sv
// Button bundle between the pad inputs, the debouncer and its consumers.
// master = debouncer side, slave = consumer / pad-driver side.
interface snac_button_debouncer_if #(
    parameter int NUM_BUTTONS = 16
);

    logic [NUM_BUTTONS-1:0] btn_raw;
    logic [NUM_BUTTONS-1:0] btn_stable;
    logic [NUM_BUTTONS-1:0] btn_rise;
    logic [NUM_BUTTONS-1:0] btn_fall;
    logic                   any_change;

    modport master (
        input  btn_raw,
        output btn_stable,
        output btn_rise,
        output btn_fall,
        output any_change
    );

    modport slave (
        output btn_raw,
        input  btn_stable,
        input  btn_rise,
        input  btn_fall,
        input  any_change
    );

endinterface

// File: rtl/snac_button_debounce_lane.sv
// One button lane: synchroniser, debounce FSM and dwell counter.
// hit flags the cycle that commits a new level, for the shared any_change flop.
module snac_button_debounce_lane
    import snac_btn_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int LIMIT       = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    input  logic advance,
    output logic stable,
    output logic rise,
    output logic fall,
    output logic hit
);

    localparam int CW = $clog2(LIMIT);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    btn_state_t             state;
    logic [CW-1:0]          cnt;
    logic                   last;

    assign s    = sync[SYNC_STAGES-1];
    assign last = advance && (cnt == CW'(LIMIT - 1));
    assign hit  = last && (((state == S_CHK_HI) && s) ||
                           ((state == S_CHK_LO) && !s));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync <= '0;
        else       sync <= {sync[SYNC_STAGES-2:0], raw};
    end

    // The sample that opens a check is the first of the LIMIT it must see.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_LO;
            cnt    <= '0;
            stable <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            unique case (state)
                S_LO: begin
                    if (s) begin
                        state <= S_CHK_HI;
                        cnt   <= CW'(advance);
                    end
                end
                S_CHK_HI: begin
                    if (!s) begin
                        state <= S_LO;
                        cnt   <= '0;
                    end else if (last) begin
                        state  <= S_HI;
                        stable <= 1'b1;
                        rise   <= 1'b1;
                        cnt    <= '0;
                    end else if (advance) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_HI: begin
                    if (!s) begin
                        state <= S_CHK_LO;
                        cnt   <= CW'(advance);
                    end
                end
                S_CHK_LO: begin
                    if (s) begin
                        state <= S_HI;
                        cnt   <= '0;
                    end else if (last) begin
                        state  <= S_LO;
                        stable <= 1'b0;
                        fall   <= 1'b1;
                        cnt    <= '0;
                    end else if (advance) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= S_LO;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/snac_button_debouncer.sv
// Debounces the SNAC/Analogizer pad buttons into clean levels and edge pulses.
// Define BTN_DEBOUNCE_PRESCALE_EN to count dwell in prescaled ticks.
module snac_button_debouncer
    import snac_btn_pkg::*;
#(
    parameter int NUM_BUTTONS     = DEF_NUM_BUTTONS,
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int TICK_DIV        = DEF_TICK_DIV,
    parameter int DEBOUNCE_TICKS  = DEF_DEBOUNCE_TICKS
) (
    input  logic clk,
    input  logic reset,
    snac_button_debouncer_if.master bus
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("SYNC_STAGES must be 2..4");
    end
    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_TICKS < 2 || TICK_DIV < 1) begin : g_bad_limit
        $error("debounce limits out of range");
    end

    logic advance;

`ifdef BTN_DEBOUNCE_PRESCALE_EN
    localparam int LIMIT = DEBOUNCE_TICKS;
    localparam int PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0] pre;

    assign advance = (pre == PW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)        pre <= '0;
        else if (advance) pre <= '0;
        else              pre <= pre + PW'(1);
    end
`else
    localparam int LIMIT = DEBOUNCE_CYCLES;

    assign advance = 1'b1;
`endif

    logic [NUM_BUTTONS-1:0] stable;
    logic [NUM_BUTTONS-1:0] rise;
    logic [NUM_BUTTONS-1:0] fall;
    logic [NUM_BUTTONS-1:0] hit;

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_lane
        snac_button_debounce_lane #(
            .SYNC_STAGES (SYNC_STAGES),
            .LIMIT       (LIMIT)
        ) u_lane (
            .clk     (clk),
            .reset   (reset),
            .raw     (bus.btn_raw[i]),
            .advance (advance),
            .stable  (stable[i]),
            .rise    (rise[i]),
            .fall    (fall[i]),
            .hit     (hit[i])
        );
    end

    assign bus.btn_stable = stable;
    assign bus.btn_rise   = rise;
    assign bus.btn_fall   = fall;

    // Registered from the lanes' commit decision so it lines up with rise/fall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) bus.any_change <= 1'b0;
        else       bus.any_change <= |hit;
    end

endmodule

// File: tb/tb_snac_button_debouncer.sv
// Self-checking bench for snac_button_debouncer against a run-length reference model.
// Build with BTN_DEBOUNCE_PRESCALE_EN defined to exercise the prescaled variant.
module tb_snac_button_debouncer;

    localparam int N  = 4;
    localparam int SS = 2;
    localparam int DC = 8;
    localparam int TD = 4;
    localparam int DT = 3;
`ifdef BTN_DEBOUNCE_PRESCALE_EN
    localparam int LIM = DT;
`else
    localparam int LIM = DC;
`endif

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    snac_button_debouncer_if #(.NUM_BUTTONS(N)) bus ();

    snac_button_debouncer #(
        .NUM_BUTTONS     (N),
        .SYNC_STAGES     (SS),
        .DEBOUNCE_CYCLES (DC),
        .TICK_DIV        (TD),
        .DEBOUNCE_TICKS  (DT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference: s is btn_raw delayed SS clocks; a lane flips once LIM
    // advancing samples in a row disagree with its current level.
    logic [N-1:0] m_pipe [SS];
    int           m_run  [N];
    int           m_pre;
    logic [N-1:0] m_stable, m_rise, m_fall;
    logic         m_any;

    task automatic model_step();
        logic [N-1:0] s;
        logic adv;
        s = m_pipe[SS-1];
`ifdef BTN_DEBOUNCE_PRESCALE_EN
        adv = (m_pre == TD - 1);
        m_pre = adv ? 0 : m_pre + 1;
`else
        adv = 1'b1;
`endif
        m_rise = '0;
        m_fall = '0;
        for (int i = 0; i < N; i++) begin
            if (s[i] != m_stable[i]) begin
                if (adv) m_run[i]++;
                if (m_run[i] == LIM) begin
                    m_stable[i] = s[i];
                    if (s[i]) m_rise[i] = 1'b1;
                    else      m_fall[i] = 1'b1;
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_any = |{m_rise, m_fall};
        for (int k = SS - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
        m_pipe[0] = bus.btn_raw;
    endtask

    task automatic model_clear();
        for (int k = 0; k < SS; k++) m_pipe[k] = '0;
        for (int i = 0; i < N; i++) m_run[i] = 0;
        m_pre = 0;
        m_stable = '0;
        m_rise = '0;
        m_fall = '0;
        m_any = 1'b0;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) model_clear();
        else       model_step();
    end

    logic [3*N:0] got, exp;
    assign got = {bus.btn_stable, bus.btn_rise, bus.btn_fall, bus.any_change};
    assign exp = {m_stable, m_rise, m_fall, m_any};

    task automatic test_reset();
        reset = 1'b1;
        bus.btn_raw = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if (got !== '0) begin
            miscompares++;
            $display("FAIL reset_state got=%h exp=0", got);
        end
        reset = 1'b0;
    endtask

    task automatic test_press();
        int rise_at = -1;
        int rises = 0;
        int anys = 0;
        bus.btn_raw[0] = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL press_model c=%0d got=%h exp=%h", c, got, exp);
            end
            if (bus.btn_rise[0]) begin
                rises++;
                if (rise_at < 0) rise_at = c;
                if (bus.any_change) anys++;
            end
        end
        vectors++;
`ifdef BTN_DEBOUNCE_PRESCALE_EN
        if (rise_at < SS + (LIM - 1) * TD + 1 || rise_at > SS + LIM * TD) begin
`else
        if (rise_at < SS + LIM - 1 || rise_at > SS + LIM + 1) begin
`endif
            miscompares++;
            $display("FAIL press_latency got=%0d", rise_at);
        end
        vectors++;
        if (rises !== 1 || anys !== 1) begin
            miscompares++;
            $display("FAIL press_pulse rises=%0d anys=%0d exp 1/1", rises, anys);
        end
        vectors++;
        if (bus.btn_stable[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL press_level got=%b exp=1", bus.btn_stable[0]);
        end
    endtask

    task automatic test_glitch();
        int evts = 0;
`ifdef BTN_DEBOUNCE_PRESCALE_EN
        int len = 6;
`else
        int len = 5;
`endif
        bus.btn_raw[1] = 1'b1;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            if (c == len) bus.btn_raw[1] = 1'b0;
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL glitch_model c=%0d got=%h exp=%h", c, got, exp);
            end
            if (bus.btn_rise[1] || bus.btn_fall[1] || bus.btn_stable[1]) evts++;
        end
        vectors++;
        if (evts !== 0) begin
            miscompares++;
            $display("FAIL glitch_reject events=%0d exp=0", evts);
        end
    endtask

    task automatic test_boundary();
        for (int len = LIM - 1; len <= LIM; len++) begin
            int rise_at = -1;
            int fall_at = -1;
            bus.btn_raw[2] = 1'b1;
            for (int c = 1; c <= 30; c++) begin
                @(negedge clk);
                if (c == len) bus.btn_raw[2] = 1'b0;
                vectors++;
                if (got !== exp) begin
                    miscompares++;
                    $display("FAIL bound_model len=%0d c=%0d got=%h exp=%h", len, c, got, exp);
                end
                if (bus.btn_rise[2] && rise_at < 0) rise_at = c;
                if (bus.btn_fall[2] && fall_at < 0) fall_at = c;
            end
`ifndef BTN_DEBOUNCE_PRESCALE_EN
            vectors++;
            if (len == LIM - 1 && (rise_at !== -1 || fall_at !== -1)) begin
                miscompares++;
                $display("FAIL bound_short rise=%0d fall=%0d exp none", rise_at, fall_at);
            end
            vectors++;
            if (len == LIM && (rise_at !== SS + LIM || fall_at !== 2 * LIM + SS)) begin
                miscompares++;
                $display("FAIL bound_exact rise=%0d fall=%0d exp %0d/%0d",
                         rise_at, fall_at, SS + LIM, 2 * LIM + SS);
            end
`endif
        end
    endtask

    task automatic test_back_to_back();
        int full = 0;
        int part = 0;
        int anys = 0;
        bus.btn_raw = '0;
        repeat (20) @(negedge clk);
        bus.btn_raw = 4'b1111;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL all_model c=%0d got=%h exp=%h", c, got, exp);
            end
            if (bus.btn_rise == 4'b1111) full++;
            else if (bus.btn_rise != 4'b0000) part++;
            if (bus.any_change) anys++;
        end
        vectors++;
        if (full !== 1 || part !== 0 || anys !== 1) begin
            miscompares++;
            $display("FAIL all_lanes full=%0d part=%0d any=%0d exp 1/0/1", full, part, anys);
        end
    endtask

    task automatic test_reset_mid();
        int rise_at = -1;
        int early = 0;
        bus.btn_raw = '0;
        repeat (20) @(negedge clk);
        bus.btn_raw[3] = 1'b1;
        repeat (SS + 5) @(negedge clk);
        reset = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (bus.btn_rise != 0 || bus.any_change) early++;
        end
        reset = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL rmid_model c=%0d got=%h exp=%h", c, got, exp);
            end
            if (bus.btn_rise[3] && rise_at < 0) rise_at = c;
        end
        vectors++;
        if (early !== 0) begin
            miscompares++;
            $display("FAIL rmid_pulse_in_reset got=%0d exp=0", early);
        end
`ifndef BTN_DEBOUNCE_PRESCALE_EN
        vectors++;
        if (rise_at !== SS + LIM) begin
            miscompares++;
            $display("FAIL rmid_rerise got=%0d exp=%0d", rise_at, SS + LIM);
        end
`endif
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL random c=%0d got=%h exp=%h", c, got, exp);
            end
            if ((bus.btn_rise & bus.btn_fall) != 0) begin
                miscompares++;
                $display("FAIL rise_and_fall c=%0d got=%b", c, bus.btn_rise & bus.btn_fall);
            end
            if ($urandom_range(0, 5) == 0) bus.btn_raw = 4'($urandom);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.btn_raw = '0;
        test_reset();
        test_press();
        test_glitch();
        test_boundary();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
